// File: rtl/word_rx_pkg.sv
// ============================================================
// word_rx_pkg : shared host-link constants and receive states
// Rev 1.0
// ============================================================
`default_nettype none

package word_rx_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      HOLD = 2'd2
   } rx_state_t;

   // A disabled timeout (0 cycles) still needs a one-bit counter.
   function automatic int timer_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/word_rx_if.sv
// ============================================================
// word_rx_if : byte strobe in, word valid/ack out, status pulses
// Rev 1.0
// ============================================================
`default_nettype none

interface word_rx_if;
   import word_rx_pkg::*;

   logic [BYTE_W-1:0] byte_in;
   logic              byte_valid;
   logic [WORD_W-1:0] word_out;
   logic              word_valid;
   logic              word_ack;
   logic              busy;
   logic              timeout;
   logic              overrun;

   modport master (
      output byte_in, byte_valid, word_ack,
      input  word_out, word_valid, busy, timeout, overrun
   );

   modport slave (
      input  byte_in, byte_valid, word_ack,
      output word_out, word_valid, busy, timeout, overrun
   );

endinterface

`default_nettype wire

// File: rtl/word_rx_byte_timer.sv
// ============================================================
// rx_byte_timer : saturating inter-byte gap counter
// Rev 1.0
// ============================================================
`default_nettype none

module rx_byte_timer
   import word_rx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int              CNT_W   = timer_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LIMIT   =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired = 1'b0;
   end else begin : g_timeout
      assign expired = (count_q == LIMIT);
   end

endmodule

`default_nettype wire

// File: rtl/word_rx.sv
// ============================================================
// word_rx : assembles four LSB-first bytes into a 32-bit word
// Rev 1.0
// ============================================================
`default_nettype none

module word_rx
   import word_rx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic        clk,
   input  logic        rst,
   word_rx_if.slave    bus
);

   localparam int         ASM_W     = (BYTES_PER_WORD - 1) * BYTE_W;
   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   rx_state_t         state_q, state_d;
   logic [1:0]        byte_count_q, byte_count_d;
   logic [ASM_W-1:0]  asm_q, asm_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              word_valid_q, word_valid_d;
   logic              timeout_q, timeout_d;
   logic              overrun_q, overrun_d;
   logic              timer_clear;
   logic              timer_expired;

   // Gap timer only runs between bytes of a partial word.
   assign timer_clear = (state_q != RECV) || bus.byte_valid;

   rx_byte_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (1'b1),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         byte_count_q <= '0;
         asm_q        <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_count_q <= byte_count_d;
         asm_q        <= asm_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         timeout_q    <= timeout_d;
         overrun_q    <= overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      byte_count_d = byte_count_q;
      asm_d        = asm_q;
      word_d       = word_q;
      word_valid_d = word_valid_q;
      timeout_d    = 1'b0;
      overrun_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.byte_valid) begin
               asm_d[BYTE_W-1:0] = bus.byte_in;
               byte_count_d      = 2'd1;
               state_d           = RECV;
            end
         end
         RECV: begin
            if (bus.byte_valid) begin
               if (byte_count_q == LAST_LANE) begin
                  word_d       = {bus.byte_in, asm_q};
                  word_valid_d = 1'b1;
                  byte_count_d = '0;
                  state_d      = HOLD;
               end else begin
                  for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
                     if (byte_count_q == 2'(i)) begin
                        asm_d[i*BYTE_W +: BYTE_W] = bus.byte_in;
                     end
                  end
                  byte_count_d = byte_count_q + 2'd1;
               end
            end else if (timer_expired) begin
               timeout_d    = 1'b1;
               byte_count_d = '0;
               state_d      = IDLE;
            end
         end
         HOLD: begin
            if (bus.word_ack) begin
               word_valid_d = 1'b0;
               if (bus.byte_valid) begin
                  asm_d[BYTE_W-1:0] = bus.byte_in;
                  byte_count_d      = 2'd1;
                  state_d           = RECV;
               end else begin
                  state_d = IDLE;
               end
            end else if (bus.byte_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d      = IDLE;
            byte_count_d = '0;
         end
      endcase
   end

   always_comb begin
      bus.word_out   = word_q;
      bus.word_valid = word_valid_q;
      bus.busy       = (state_q == RECV);
      bus.timeout    = timeout_q;
      bus.overrun    = overrun_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_word_rx.sv
// ============================================================
// tb_word_rx : scoreboard bench for word_rx with a queue-based model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_word_rx;
   import word_rx_pkg::*;

   localparam int T = 16;
   localparam int EV_WORD = 0;
   localparam int EV_TO   = 1;
   localparam int EV_OV   = 2;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   word_rx_if bus ();

   word_rx #(.TIMEOUT_CYCLES(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: bytes of the partial word in a queue, plus held word.
   bit          m_valid = 1'b0;
   logic [31:0] m_word  = 32'h0;
   logic [7:0]  m_bytes[$];
   int          m_idle  = 0;
   bit          m_to    = 1'b0;
   bit          m_ov    = 1'b0;
   ev_t         sb[$];
   bit          mon_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_step(input bit bv, input logic [7:0] b, input bit ack, input bit r);
      m_to = 1'b0;
      m_ov = 1'b0;
      if (r) begin
         m_valid = 1'b0;
         m_word  = 32'h0;
         m_bytes.delete();
         m_idle  = 0;
      end else if (m_valid) begin
         if (ack) begin
            m_valid = 1'b0;
            if (bv) begin
               m_bytes.push_back(b);
               m_idle = 0;
            end
         end else if (bv) begin
            m_ov = 1'b1;
            sb.push_back('{EV_OV, 32'h0});
         end
      end else if (bv) begin
         m_bytes.push_back(b);
         m_idle = 0;
         if (m_bytes.size() == 4) begin
            m_word  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_valid = 1'b1;
            m_bytes.delete();
            sb.push_back('{EV_WORD, m_word});
         end
      end else if (m_bytes.size() > 0) begin
         m_idle++;
         if (m_idle == T) begin
            m_to = 1'b1;
            m_bytes.delete();
            sb.push_back('{EV_TO, 32'h0});
         end
      end
   endtask

   task automatic cycle(input bit bv, input logic [7:0] b, input bit ack, input bit r);
      @(negedge clk);
      #1;
      bus.byte_valid = bv;
      bus.byte_in    = b;
      bus.word_ack   = ack;
      rst            = r;
      model_step(bv, b, ack, r);
      @(posedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
   endtask

   task automatic peek(input string name, input logic [31:0] word, input bit valid);
      #1;
      chk({name, "_word"}, bus.word_out, word);
      chk({name, "_valid"}, {31'h0, bus.word_valid}, {31'h0, valid});
   endtask

   task automatic pop_expect(input string name, input int kind, input logic [31:0] data);
      ev_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s actual=event required=none", name);
      end else begin
         e = sb.pop_front();
         chk({name, "_kind"}, kind, e.kind);
         if (kind == EV_WORD) chk(name, data, e.data);
      end
   endtask

   // Monitor: per-cycle output compare plus scoreboard pops on DUT events.
   initial begin
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("word_valid", {31'h0, bus.word_valid}, {31'h0, m_valid});
            chk("word_out", bus.word_out, m_word);
            chk("busy", {31'h0, bus.busy}, {31'h0, m_bytes.size() > 0});
            chk("timeout", {31'h0, bus.timeout}, {31'h0, m_to});
            chk("overrun", {31'h0, bus.overrun}, {31'h0, m_ov});
            if (bus.word_valid && !prev_valid) pop_expect("sb_word", EV_WORD, bus.word_out);
            if (bus.timeout) pop_expect("sb_timeout", EV_TO, 32'h0);
            if (bus.overrun) pop_expect("sb_overrun", EV_OV, 32'h0);
            prev_valid = bus.word_valid;
         end
      end
   end

   initial begin
      int p;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      bus.word_ack   = 1'b0;
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      mon_en = 1'b1;
      peek("reset", 32'h0, 1'b0);

      // Spaced bytes, long hold, then ack.
      send(8'h78); idle(9); send(8'h56); idle(9); send(8'h34); idle(9); send(8'h12);
      peek("spaced", 32'h12345678, 1'b1);
      idle(50);
      peek("hold50", 32'h12345678, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      peek("acked", 32'h12345678, 1'b0);

      // Back-to-back bytes.
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      peek("b2b", 32'hEFBEADDE, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Timeout, then bytes arriving on the last permitted cycle.
      send(8'hA1); send(8'hA2); idle(20);
      peek("timeout", 32'hEFBEADDE, 1'b0);
      send(8'h01); send(8'h02); idle(15); send(8'h03); idle(15); send(8'h04);
      peek("edge", 32'h04030201, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Overrun, then ack with a byte in the same cycle.
      send(8'h0D); send(8'hF0); send(8'hFE); send(8'hCA);
      send(8'hAA);
      peek("overrun", 32'hCAFEF00D, 1'b1);
      cycle(1'b1, 8'h11, 1'b1, 1'b0);
      send(8'h22); send(8'h33); send(8'h44);
      peek("ack_byte", 32'h44332211, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset mid-word.
      send(8'h5A); send(8'h6B); send(8'h7C);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      peek("mid_rst", 32'h0, 1'b0);
      chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
      send(8'h10); send(8'h20); send(8'h30); send(8'h40);
      peek("post_rst", 32'h40302010, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Ack with no word pending.
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic with varying byte density.
      for (int ph = 0; ph < 20; ph++) begin
         case ($urandom % 3)
            0:       p = 5;
            1:       p = 40;
            default: p = 90;
         endcase
         for (int i = 0; i < 200; i++) begin
            cycle(($urandom % 100) < p, 8'($urandom), ($urandom % 100) < 25,
                  ($urandom % 300) == 0);
         end
      end

      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      idle(20);
      @(negedge clk);
      chk("sb_drained", sb.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
